gray_clk_monitor: RTL and testbench

- Sits directly downstream of the gray tree: consumes the 11-bit gray clock bus and one q_sine output, all in the clk_master domain.
- Decodes the bus to a binary phase and checks every transition for legal single-step gray increments.
- Tracks lock status, counts errors, and produces a per-channel tick strobe and a measured q_sine period for the channel datapath and debug readout.

---
 rtl/gray_clk_monitor.sv | 157 +++++++++++++++
 tb/tb_gray_clk_monitor.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_clk_monitor.sv
// Gray clock bus monitor: decodes the bus to binary phase, checks every
// transition for a legal +1 gray step, tracks lock, counts errors, times q_sine.
// Ports: clk_master/rstb clock and async reset; gray_clk/q_sine monitored inputs;
// tick_sel picks the tick bit; err_clr clears err_count; phase_bin/tick/wrap/err
// pulses; err_count, locked, sine_period/sine_valid status.
module gray_clk_monitor #(
  parameter int WIDTH      = 11,
  parameter int LOCK_STEPS = 4,
  parameter int ERR_W      = 8,
  parameter int PER_W      = 16
) (
  input  logic             clk_master,
  input  logic             rstb,
  input  logic [WIDTH-1:0] gray_clk,
  input  logic             q_sine,
  input  logic [3:0]       tick_sel,
  input  logic             err_clr,
  output logic [WIDTH-1:0] phase_bin,
  output logic             tick,
  output logic             wrap,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked,
  output logic [PER_W-1:0] sine_period,
  output logic             sine_valid
);

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_STEPS);

  state_t           state, state_n;
  logic [3:0]       step_cnt, step_cnt_n;
  logic [WIDTH-1:0] g1, g1_d;
  logic [WIDTH-1:0] b1, b1_d, diff;
  logic [15:0]      gx, gdx;
  logic             s1, s1_d;
  logic             first, s_seen;
  logic [PER_W-1:0] per_cnt;
  logic             chg, one_hot, legal, illegal;
  logic             in_rng, tick_n;

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  assign b1      = g2b(g1);
  assign b1_d    = g2b(g1_d);
  assign diff    = g1 ^ g1_d;
  assign chg     = first && (diff != '0);
  assign one_hot = (diff & (diff - WIDTH'(1))) == '0;
  assign legal   = chg && one_hot
                && (b1 == b1_d + WIDTH'(1));
  assign illegal = chg && !legal;

  // Zero-padded copies so tick_sel beyond the bus stays in range.
  assign gx     = 16'(g1);
  assign gdx    = 16'(g1_d);
  assign in_rng = 32'(tick_sel) < WIDTH;
  assign tick_n = in_rng && gx[tick_sel] && !gdx[tick_sel];

  always_comb begin
    state_n    = state;
    step_cnt_n = step_cnt;
    unique case (state)
      UNLOCKED: begin
        if (legal) begin
          step_cnt_n = 4'd1;
          state_n    = (LOCK_N <= 4'd1) ? LOCKED : ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (illegal) begin
          state_n    = UNLOCKED;
          step_cnt_n = '0;
        end else if (legal) begin
          step_cnt_n = step_cnt + 4'd1;
          if (step_cnt_n == LOCK_N)
            state_n = LOCKED;
        end
      end
      LOCKED: begin
        if (illegal) begin
          state_n    = UNLOCKED;
          step_cnt_n = '0;
        end
      end
      default: begin
        state_n    = UNLOCKED;
        step_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      g1          <= '0;
      g1_d        <= '0;
      s1          <= 1'b0;
      s1_d        <= 1'b0;
      first       <= 1'b0;
      state       <= UNLOCKED;
      step_cnt    <= '0;
      phase_bin   <= '0;
      tick        <= 1'b0;
      wrap        <= 1'b0;
      err         <= 1'b0;
      err_count   <= '0;
      locked      <= 1'b0;
      s_seen      <= 1'b0;
      per_cnt     <= '0;
      sine_period <= '0;
      sine_valid  <= 1'b0;
    end else begin
      first <= 1'b1;
      g1    <= gray_clk;
      // First sample after reset seeds both copies: a fresh baseline.
      g1_d  <= first ? g1 : gray_clk;
      s1    <= q_sine;
      s1_d  <= s1;

      state     <= state_n;
      step_cnt  <= step_cnt_n;
      locked    <= (state_n == LOCKED);
      phase_bin <= b1;
      tick      <= tick_n;
      wrap      <= legal && (b1 == '0);
      err       <= illegal;

      if (err_clr)
        err_count <= '0;
      else if (illegal && (err_count != '1))
        err_count <= err_count + ERR_W'(1);

      if (s1 && !s1_d) begin
        per_cnt <= '0;
        s_seen  <= 1'b1;
        if (s_seen) begin
          sine_period <= (per_cnt == '1) ? per_cnt
                       : per_cnt + PER_W'(1);
          sine_valid  <= 1'b1;
        end
      end else if (per_cnt != '1) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gray_clk_monitor.sv
// Bench for gray_clk_monitor: scoreboard of expected outputs pushed per cycle,
// popped two cycles later, plus directed checks per scenario.
module tb_gray_clk_monitor;

  localparam int W = 11;

  logic          clk = 1'b0;
  logic          rstb = 1'b1;
  logic [W-1:0]  gray_clk = '0;
  logic          q_sine = 1'b0;
  logic [3:0]    tick_sel = 4'd3;
  logic          err_clr = 1'b0;
  logic [W-1:0]  phase_bin;
  logic          tick, wrap, err;
  logic [7:0]    err_count;
  logic          locked;
  logic [15:0]   sine_period;
  logic          sine_valid;

  int n_cmp = 0;
  int n_bad = 0;

  gray_clk_monitor dut (
    .clk_master (clk),
    .rstb       (rstb),
    .gray_clk   (gray_clk),
    .q_sine     (q_sine),
    .tick_sel   (tick_sel),
    .err_clr    (err_clr),
    .phase_bin  (phase_bin),
    .tick       (tick),
    .wrap       (wrap),
    .err        (err),
    .err_count  (err_count),
    .locked     (locked),
    .sine_period(sine_period),
    .sine_valid (sine_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] pg;
    logic         chk;
    logic         q;
    logic         pq;
  } ent_t;

  ent_t         sbq[$];
  logic         sb_on = 1'b0;
  logic [W-1:0] cur_g = '0;
  logic         cur_q = 1'b0;
  logic [W-1:0] m_pg;
  logic         m_have, m_pq;
  int           m_lcnt, m_ecnt, m_pc, m_per;
  logic         m_seen, m_sv;
  int           n_wrap, n_tick, n_err;

  function automatic logic [W-1:0] gray(input int n);
    logic [W-1:0] v;
    v = W'(n);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [W-1:0] bin_of(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++)
      b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic m_reset();
    sbq.delete();
    m_have = 1'b0;
    m_pg   = '0;
    m_pq   = 1'b0;
    m_lcnt = 0;
    m_ecnt = 0;
    m_pc   = 0;
    m_per  = 0;
    m_seen = 1'b0;
    m_sv   = 1'b0;
  endtask

  task automatic cyc();
    logic [W-1:0] pg;
    pg = m_have ? m_pg : cur_g;
    sbq.push_back('{cur_g, pg, m_have, cur_q, m_pq});
    gray_clk = cur_g;
    q_sine   = cur_q;
    m_pg     = cur_g;
    m_have   = 1'b1;
    m_pq     = cur_q;
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic step(input int n, input int cycles);
    cur_g = gray(n);
    hold(cycles);
  endtask

  // Scoreboard monitor: runs 1 time unit after each edge.
  ent_t         e;
  logic [W-1:0] mb, mpb, md;
  logic         mlg, mil, mtk;
  logic [39:0]  ac, xp;

  always begin
    @(posedge clk);
    #1;
    if (rstb) begin
      n_wrap += int'(wrap);
      n_tick += int'(tick);
      n_err  += int'(err);
    end
    if (sb_on && rstb && sbq.size() >= 2) begin
      e   = sbq.pop_front();
      mb  = bin_of(e.g);
      mpb = bin_of(e.pg);
      md  = e.g ^ e.pg;
      mlg = e.chk && (md != '0) && ($countones(md) == 1)
         && (mb == W'(mpb + 1));
      mil = e.chk && (md != '0) && !mlg;
      mtk = (tick_sel < W) ? (e.g[tick_sel] & ~e.pg[tick_sel]) : 1'b0;
      if (mlg && m_lcnt < 15) m_lcnt++;
      if (mil) m_lcnt = 0;
      if (err_clr) m_ecnt = 0;
      else if (mil && m_ecnt < 255) m_ecnt++;
      if (e.q && !e.pq) begin
        if (m_seen) begin
          m_per = m_pc + 1;
          m_sv  = 1'b1;
        end
        m_seen = 1'b1;
        m_pc   = 0;
      end else if (m_pc < 65535) begin
        m_pc++;
      end
      xp = {mb, mtk, mlg && (mb == '0), mil, 8'(m_ecnt),
            m_lcnt >= 4, 16'(m_per), m_sv};
      ac = {phase_bin, tick, wrap, err, err_count,
            locked, sine_period, sine_valid};
      n_cmp++;
      if (ac !== xp) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t got %h want %h", $time, ac, xp);
      end
    end
  end

  task automatic test_reset();
    gray_clk = gray(77);
    q_sine   = 1'b1;
    #1 rstb  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if ({phase_bin, tick, wrap, err, err_count, locked,
         sine_period, sine_valid} !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 0",
        {phase_bin, tick, wrap, err, err_count, locked,
         sine_period, sine_valid});
    end
    m_reset();
    cur_g = gray(0);
    cur_q = 1'b0;
    gray_clk = cur_g;
    q_sine   = cur_q;
    rstb  = 1'b1;
    sb_on = 1'b1;
  endtask

  task automatic test_count();
    n_wrap = 0;
    n_err  = 0;
    hold(4);
    for (int n = 1; n <= 3; n++) step(n, 4);
    cur_g = gray(4);
    cyc();
    n_cmp++;
    if (locked !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_early got %b want 0", locked);
    end
    cyc();
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_rise got %b want 1", locked);
    end
    hold(2);
    for (int n = 5; n <= 2047; n++) step(n, 4);
    n_cmp++;
    if (phase_bin !== 11'd2047) begin
      n_bad++;
      $display("FAIL phase_top got %0d want 2047", phase_bin);
    end
    step(0, 4);
    n_cmp++;
    if (n_wrap !== 1) begin
      n_bad++;
      $display("FAIL wrap_count got %0d want 1", n_wrap);
    end
    n_cmp++;
    if (err_count !== 8'd0 || n_err !== 0) begin
      n_bad++;
      $display("FAIL count_errs got %0d/%0d want 0/0", err_count, n_err);
    end
  endtask

  task automatic test_multibit();
    for (int n = 1; n <= 10; n++) step(n, 4);
    n_err = 0;
    cur_g = gray(13);
    cyc();
    cyc();
    n_cmp++;
    if ({err, locked, err_count} !== {1'b1, 1'b0, 8'd1}) begin
      n_bad++;
      $display("FAIL jump_err got err=%b lk=%b ec=%0d want err=1 lk=0 ec=1",
        err, locked, err_count);
    end
    hold(2);
    for (int n = 14; n <= 16; n++) step(n, 4);
    n_cmp++;
    if (locked !== 1'b0 || n_err !== 1) begin
      n_bad++;
      $display("FAIL relock_early got lk=%b errs=%0d want 0/1", locked, n_err);
    end
    step(17, 4);
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL relock got %b want 1", locked);
    end
  endtask

  task automatic test_backward();
    for (int n = 18; n <= 20; n++) step(n, 4);
    n_err = 0;
    step(19, 4);
    n_cmp++;
    if (n_err !== 1 || err_count !== 8'd2 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL backward got errs=%0d ec=%0d lk=%b want 1/2/0",
        n_err, err_count, locked);
    end
    n_err = 0;
    hold(100);
    n_cmp++;
    if (n_err !== 0 || locked !== 1'b0 || err_count !== 8'd2) begin
      n_bad++;
      $display("FAIL hold got errs=%0d lk=%b ec=%0d want 0/0/2",
        n_err, locked, err_count);
    end
  endtask

  task automatic test_tick();
    int           want;
    logic [W-1:0] a, b;
    tick_sel = 4'd3;
    step(0, 4);
    n_tick = 0;
    want   = 0;
    for (int n = 1; n <= 63; n++) begin
      a = gray(n);
      b = gray(n - 1);
      if (a[3] && !b[3]) want++;
      step(n, 4);
    end
    n_cmp++;
    if (n_tick !== want) begin
      n_bad++;
      $display("FAIL tick_sel3 got %0d want %0d", n_tick, want);
    end
    tick_sel = 4'd12;
    n_tick = 0;
    for (int n = 64; n <= 127; n++) step(n, 2);
    hold(2);
    n_cmp++;
    if (n_tick !== 0) begin
      n_bad++;
      $display("FAIL tick_sel12 got %0d want 0", n_tick);
    end
  endtask

  task automatic test_sine();
    cur_q = 1'b0;
    hold(10);
    cur_q = 1'b1;
    hold(400);
    n_cmp++;
    if (sine_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sine_first got %b want 0", sine_valid);
    end
    cur_q = 1'b0;
    hold(400);
    cur_q = 1'b1;
    hold(3);
    n_cmp++;
    if (sine_valid !== 1'b1 || sine_period !== 16'd800) begin
      n_bad++;
      $display("FAIL sine_period got v=%b p=%0d want v=1 p=800",
        sine_valid, sine_period);
    end
    hold(397);
    cur_q = 1'b0;
    hold(5);
  endtask

  task automatic test_err_sat();
    n_err = 0;
    for (int i = 0; i < 300; i++) begin
      cur_g = cur_g ^ W'(3);
      hold(2);
    end
    hold(2);
    n_cmp++;
    if (err_count !== 8'd255 || n_err !== 300) begin
      n_bad++;
      $display("FAIL err_sat got ec=%0d errs=%0d want 255/300",
        err_count, n_err);
    end
    cur_g = cur_g ^ W'(3);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL err_clr got err=%b ec=%0d want 1/0", err, err_count);
    end
    hold(2);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      cur_g = cur_g ^ W'(3);
      hold(2);
    end
    hold(2);
    n_cmp++;
    if (err_count !== 8'd5) begin
      n_bad++;
      $display("FAIL pre_reset got %0d want 5", err_count);
    end
    #4 rstb = 1'b0;
    sb_on = 1'b0;
    #1;
    n_cmp++;
    if ({phase_bin, tick, wrap, err, err_count, locked,
         sine_period, sine_valid} !== 40'd0) begin
      n_bad++;
      $display("FAIL mid_reset got %h want 0",
        {phase_bin, tick, wrap, err, err_count, locked,
         sine_period, sine_valid});
    end
    @(posedge clk);
    #2;
    m_reset();
    cur_g = gray(500);
    cur_q = 1'b0;
    gray_clk = cur_g;
    rstb  = 1'b1;
    sb_on = 1'b1;
    n_err = 0;
    hold(4);
    n_cmp++;
    if (n_err !== 0 || err_count !== 8'd0) begin
      n_bad++;
      $display("FAIL baseline got errs=%0d ec=%0d want 0/0", n_err, err_count);
    end
    for (int n = 501; n <= 504; n++) step(n, 4);
    n_cmp++;
    if (locked !== 1'b1 || phase_bin !== 11'd504) begin
      n_bad++;
      $display("FAIL post_reset_lock got lk=%b ph=%0d want 1/504",
        locked, phase_bin);
    end
  endtask

  initial begin
    m_reset();
    n_wrap = 0;
    n_tick = 0;
    n_err  = 0;
    test_reset();
    test_count();
    test_multibit();
    test_backward();
    test_tick();
    test_sine();
    test_err_sat();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
